// File: rtl/mac_stop_mult_seq_if.sv
// rtl/mac_stop_mult_seq_if.sv - control, RAM read and product bundle between mac_stop_mult_seq and its neighbours
interface mac_stop_mult_seq_if #(
   parameter int M                      = 2,
   parameter int K                      = 2,
   parameter int N                      = 2,
   parameter int DATA_WIDTH_INIT_MATRIX = 32
);
   localparam int MW = $clog2(M);
   localparam int KW = $clog2(K);
   localparam int NW = $clog2(N);
   localparam int DW = DATA_WIDTH_INIT_MATRIX;

   logic            start;
   logic            busy;
   logic            done;
   logic            rd_en_a;
   logic [MW-1:0]   addr_a_row;
   logic [KW-1:0]   addr_a_col;
   logic [DW-1:0]   data_a;
   logic            rd_en_b;
   logic [KW-1:0]   addr_b_row;
   logic [NW-1:0]   addr_b_col;
   logic [DW-1:0]   data_b;
   logic [2*DW-1:0] product_reg;
   logic [MW-1:0]   matrix_a_row_addr_counter_reg;
   logic [KW-1:0]   matrix_a_col_addr_counter_reg;
   logic [KW-1:0]   matrix_b_row_addr_counter_reg;
   logic [NW-1:0]   matrix_b_col_addr_counter_reg;
   logic            mult_done_reg;

   modport master (
      input  start, data_a, data_b,
      output busy, done, rd_en_a, addr_a_row, addr_a_col, rd_en_b, addr_b_row, addr_b_col,
      output product_reg, matrix_a_row_addr_counter_reg, matrix_a_col_addr_counter_reg,
      output matrix_b_row_addr_counter_reg, matrix_b_col_addr_counter_reg, mult_done_reg
   );

   modport slave (
      output start, data_a, data_b,
      input  busy, done, rd_en_a, addr_a_row, addr_a_col, rd_en_b, addr_b_row, addr_b_col,
      input  product_reg, matrix_a_row_addr_counter_reg, matrix_a_col_addr_counter_reg,
      input  matrix_b_row_addr_counter_reg, matrix_b_col_addr_counter_reg, mult_done_reg
   );
endinterface

// File: rtl/mac_stop_mult_seq.sv
// rtl/mac_stop_mult_seq.sv - walks C = A x B index space, reads A/B RAMs, streams tagged products
module mac_stop_mult_seq #(
   parameter int M                      = 2,
   parameter int K                      = 2,
   parameter int N                      = 2,
   parameter int DATA_WIDTH_INIT_MATRIX = 32
) (
   input  logic              clk,
   input  logic              reset,
   mac_stop_mult_seq_if.master bus
);
   localparam int MW = $clog2(M);
   localparam int KW = $clog2(K);
   localparam int NW = $clog2(N);
   localparam int DW = DATA_WIDTH_INIT_MATRIX;
   localparam int PW = 2 * DW;

   localparam logic [MW-1:0] M_LAST = MW'(M - 1);
   localparam logic [KW-1:0] K_LAST = KW'(K - 1);
   localparam logic [NW-1:0] N_LAST = NW'(N - 1);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t        state_q, state_d;
   logic [MW-1:0] i_q, i_d;
   logic [NW-1:0] j_q, j_d;
   logic [KW-1:0] k_q, k_d;
   logic          drain_q, drain_d;

   // stage 2: tags travelling alongside the RAM read latency
   logic          v1_q, v1_d;
   logic [MW-1:0] ti1_q, ti1_d;
   logic [NW-1:0] tj1_q, tj1_d;
   logic [KW-1:0] tk1_q, tk1_d;

   logic          mult_done_q, mult_done_d;
   logic [PW-1:0] product_q, product_d;
   logic [MW-1:0] ti_q, ti_d;
   logic [NW-1:0] tj_q, tj_d;
   logic [KW-1:0] tk_q, tk_d;

   logic rd_en;
   logic last_k, last_j, last_i;

   assign last_k = (k_q == K_LAST);
   assign last_j = (j_q == N_LAST);
   assign last_i = (i_q == M_LAST);
   assign rd_en  = (state_q == S_ISSUE);

   always_comb begin
      state_d = state_q;
      i_d     = i_q;
      j_d     = j_q;
      k_d     = k_q;
      drain_d = drain_q;
      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               state_d = S_ISSUE;
               i_d     = '0;
               j_d     = '0;
               k_d     = '0;
            end
         end
         S_ISSUE: begin
            // counters wrap back to zero on the last triple, so they idle at (0,0,0)
            if (last_k) begin
               k_d = '0;
               if (last_j) begin
                  j_d = '0;
                  i_d = last_i ? '0 : i_q + 1'b1;
               end else begin
                  j_d = j_q + 1'b1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
            if (last_k && last_j && last_i) begin
               state_d = S_DRAIN;
               drain_d = 1'b0;
            end
         end
         S_DRAIN: begin
            drain_d = 1'b1;
            if (drain_q) state_d = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      v1_d        = rd_en;
      ti1_d       = i_q;
      tj1_d       = j_q;
      tk1_d       = k_q;
      mult_done_d = v1_q;
      product_d   = product_q;
      ti_d        = ti_q;
      tj_d        = tj_q;
      tk_d        = tk_q;
      // product and tags hold their last values between passes
      if (v1_q) begin
         product_d = PW'(bus.data_a) * PW'(bus.data_b);
         ti_d      = ti1_q;
         tj_d      = tj1_q;
         tk_d      = tk1_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         i_q         <= '0;
         j_q         <= '0;
         k_q         <= '0;
         drain_q     <= 1'b0;
         v1_q        <= 1'b0;
         ti1_q       <= '0;
         tj1_q       <= '0;
         tk1_q       <= '0;
         mult_done_q <= 1'b0;
         product_q   <= '0;
         ti_q        <= '0;
         tj_q        <= '0;
         tk_q        <= '0;
      end else begin
         state_q     <= state_d;
         i_q         <= i_d;
         j_q         <= j_d;
         k_q         <= k_d;
         drain_q     <= drain_d;
         v1_q        <= v1_d;
         ti1_q       <= ti1_d;
         tj1_q       <= tj1_d;
         tk1_q       <= tk1_d;
         mult_done_q <= mult_done_d;
         product_q   <= product_d;
         ti_q        <= ti_d;
         tj_q        <= tj_d;
         tk_q        <= tk_d;
      end
   end

   assign bus.busy       = (state_q != S_IDLE);
   assign bus.done       = (state_q == S_DONE);
   assign bus.rd_en_a    = rd_en;
   assign bus.rd_en_b    = rd_en;
   assign bus.addr_a_row = i_q;
   assign bus.addr_a_col = k_q;
   assign bus.addr_b_row = k_q;
   assign bus.addr_b_col = j_q;

   assign bus.product_reg                   = product_q;
   assign bus.matrix_a_row_addr_counter_reg = ti_q;
   assign bus.matrix_a_col_addr_counter_reg = tk_q;
   assign bus.matrix_b_row_addr_counter_reg = tk_q;
   assign bus.matrix_b_col_addr_counter_reg = tj_q;
   assign bus.mult_done_reg                 = mult_done_q;
endmodule

// File: tb/tb_mac_stop_mult_seq.sv
// tb/tb_mac_stop_mult_seq.sv - randomized self-checking bench for mac_stop_mult_seq (2x2x2 and 3x5x5)
module tb_mac_stop_mult_seq;
   localparam int SEL_BUSY = 0, SEL_DONE = 1, SEL_RDA = 2, SEL_RDB = 3, SEL_MD = 4, SEL_PROD = 5;
   localparam int SEL_TI = 6, SEL_TJ = 7, SEL_TKA = 8, SEL_TKB = 9;
   localparam int SEL_AR = 10, SEL_AC = 11, SEL_BR = 12, SEL_BC = 13;

   logic clk = 1'b0;
   logic rst0, rst1;
   int   checks = 0;
   int   failures = 0;

   always #5 clk = ~clk;

   mac_stop_mult_seq_if #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) if0 ();
   mac_stop_mult_seq_if #(.M(3), .K(5), .N(5), .DATA_WIDTH_INIT_MATRIX(32)) if1 ();

   mac_stop_mult_seq #(.M(2), .K(2), .N(2), .DATA_WIDTH_INIT_MATRIX(32)) u_dut0 (
      .clk(clk), .reset(rst0), .bus(if0.master));
   mac_stop_mult_seq #(.M(3), .K(5), .N(5), .DATA_WIDTH_INIT_MATRIX(32)) u_dut1 (
      .clk(clk), .reset(rst1), .bus(if1.master));

   logic [31:0] a0 [2][2];
   logic [31:0] b0 [2][2];
   logic [31:0] a1 [3][5];
   logic [31:0] b1 [5][5];

   // synchronous-read RAM models
   always @(posedge clk) begin
      if (if0.rd_en_a) if0.data_a <= a0[if0.addr_a_row][if0.addr_a_col];
      if (if0.rd_en_b) if0.data_b <= b0[if0.addr_b_row][if0.addr_b_col];
      if (if1.rd_en_a) if1.data_a <= a1[if1.addr_a_row][if1.addr_a_col];
      if (if1.rd_en_b) if1.data_b <= b1[if1.addr_b_row][if1.addr_b_col];
   end

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [63:0] obs(input int inst, input int sel);
      logic [63:0] v;
      v = '0;
      if (inst == 0) begin
         case (sel)
            SEL_BUSY: v = 64'(if0.busy);
            SEL_DONE: v = 64'(if0.done);
            SEL_RDA:  v = 64'(if0.rd_en_a);
            SEL_RDB:  v = 64'(if0.rd_en_b);
            SEL_MD:   v = 64'(if0.mult_done_reg);
            SEL_PROD: v = if0.product_reg;
            SEL_TI:   v = 64'(if0.matrix_a_row_addr_counter_reg);
            SEL_TJ:   v = 64'(if0.matrix_b_col_addr_counter_reg);
            SEL_TKA:  v = 64'(if0.matrix_a_col_addr_counter_reg);
            SEL_TKB:  v = 64'(if0.matrix_b_row_addr_counter_reg);
            SEL_AR:   v = 64'(if0.addr_a_row);
            SEL_AC:   v = 64'(if0.addr_a_col);
            SEL_BR:   v = 64'(if0.addr_b_row);
            SEL_BC:   v = 64'(if0.addr_b_col);
            default:  v = '0;
         endcase
      end else begin
         case (sel)
            SEL_BUSY: v = 64'(if1.busy);
            SEL_DONE: v = 64'(if1.done);
            SEL_RDA:  v = 64'(if1.rd_en_a);
            SEL_RDB:  v = 64'(if1.rd_en_b);
            SEL_MD:   v = 64'(if1.mult_done_reg);
            SEL_PROD: v = if1.product_reg;
            SEL_TI:   v = 64'(if1.matrix_a_row_addr_counter_reg);
            SEL_TJ:   v = 64'(if1.matrix_b_col_addr_counter_reg);
            SEL_TKA:  v = 64'(if1.matrix_a_col_addr_counter_reg);
            SEL_TKB:  v = 64'(if1.matrix_b_row_addr_counter_reg);
            SEL_AR:   v = 64'(if1.addr_a_row);
            SEL_AC:   v = 64'(if1.addr_a_col);
            SEL_BR:   v = 64'(if1.addr_b_row);
            SEL_BC:   v = 64'(if1.addr_b_col);
            default:  v = '0;
         endcase
      end
      return v;
   endfunction

   // OR of every output; zero means the block is fully quiet
   function automatic logic [63:0] all_out(input int inst);
      logic [63:0] v;
      v = '0;
      for (int s = SEL_BUSY; s <= SEL_BC; s++) v = v | obs(inst, s);
      return v;
   endfunction

   function automatic logic [31:0] elem(input int inst, input bit is_b, input int r, input int c);
      if (inst == 0) return is_b ? b0[r][c] : a0[r][c];
      return is_b ? b1[r][c] : a1[r][c];
   endfunction

   task automatic set_start(input int inst, input logic v);
      if (inst == 0) if0.start = v;
      else           if1.start = v;
   endtask

   task automatic set_rst(input int inst, input logic v);
      if (inst == 0) rst0 = v;
      else           rst1 = v;
   endtask

   // Called right after a negedge with the DUT idle. noise_c injects a start during that cycle;
   // rst_after > 0 asserts reset once that many products have been seen.
   task automatic run_pass(input int inst, input int noise_c, input int rst_after);
      int m, k, n, mnk, busy_cnt, idx;
      logic [63:0] exp_p[$];
      int exp_i[$], exp_j[$], exp_k[$];
      logic [63:0] last_p;
      int last_i, last_j, last_k;
      m = (inst == 0) ? 2 : 3;
      k = (inst == 0) ? 2 : 5;
      n = (inst == 0) ? 2 : 5;
      mnk = m * n * k;
      for (int i = 0; i < m; i++)
         for (int j = 0; j < n; j++)
            for (int kk = 0; kk < k; kk++) begin
               exp_p.push_back(64'(elem(inst, 1'b0, i, kk)) * 64'(elem(inst, 1'b1, kk, j)));
               exp_i.push_back(i);
               exp_j.push_back(j);
               exp_k.push_back(kk);
            end
      last_p = exp_p[mnk-1];
      last_i = m - 1;
      last_j = n - 1;
      last_k = k - 1;
      busy_cnt = 0;
      set_start(inst, 1'b1);
      for (int c = 1; c <= mnk + 4; c++) begin
         @(negedge clk);
         if (obs(inst, SEL_BUSY) == 64'd1) busy_cnt++;
         chk_eq("busy", obs(inst, SEL_BUSY), 64'(c <= mnk + 3));
         chk_eq("done", obs(inst, SEL_DONE), 64'(c == mnk + 3));
         chk_eq("rd_en_a", obs(inst, SEL_RDA), 64'(c <= mnk));
         chk_eq("rd_en_b", obs(inst, SEL_RDB), 64'(c <= mnk));
         chk_eq("mult_done", obs(inst, SEL_MD), 64'(c >= 3 && c <= mnk + 2));
         if (c <= mnk) begin
            idx = c - 1;
            chk_eq("addr_a_row", obs(inst, SEL_AR), 64'(idx / (k * n)));
            chk_eq("addr_a_col", obs(inst, SEL_AC), 64'(idx % k));
            chk_eq("addr_b_row", obs(inst, SEL_BR), 64'(idx % k));
            chk_eq("addr_b_col", obs(inst, SEL_BC), 64'((idx / k) % n));
         end
         if (c >= 3 && c <= mnk + 2 && exp_p.size() > 0) begin
            chk_eq("product", obs(inst, SEL_PROD), exp_p.pop_front());
            chk_eq("tag_i", obs(inst, SEL_TI), 64'(exp_i.pop_front()));
            chk_eq("tag_j", obs(inst, SEL_TJ), 64'(exp_j.pop_front()));
            idx = exp_k.pop_front();
            chk_eq("tag_k_a", obs(inst, SEL_TKA), 64'(idx));
            chk_eq("tag_k_b", obs(inst, SEL_TKB), 64'(idx));
         end
         if (c == mnk + 4) begin
            chk_eq("hold_product", obs(inst, SEL_PROD), last_p);
            chk_eq("hold_tag_i", obs(inst, SEL_TI), 64'(last_i));
            chk_eq("hold_tag_j", obs(inst, SEL_TJ), 64'(last_j));
            chk_eq("hold_tag_k", obs(inst, SEL_TKA), 64'(last_k));
            chk_eq("busy_cycles", 64'(busy_cnt), 64'(mnk + 3));
         end
         if (rst_after > 0 && c == 2 + rst_after) begin
            set_start(inst, 1'b0);
            set_rst(inst, 1'b1);
            @(negedge clk);
            chk_eq("abort_outputs", all_out(inst), 64'd0);
            set_rst(inst, 1'b0);
            for (int q = 0; q < 4; q++) begin
               @(negedge clk);
               chk_eq("abort_quiet", all_out(inst), 64'd0);
            end
            return;
         end
         set_start(inst, (c == noise_c) || (c == mnk + 3));
      end
      set_start(inst, 1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      rst0 = 1'b1;
      rst1 = 1'b1;
      if0.start = 1'b0;
      if1.start = 1'b0;
      if0.data_a = '0; if0.data_b = '0;
      if1.data_a = '0; if1.data_b = '0;
      a0[0][0] = 1; a0[0][1] = 2; a0[1][0] = 3; a0[1][1] = 4;
      b0[0][0] = 5; b0[0][1] = 6; b0[1][0] = 7; b0[1][1] = 8;
      for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) a1[r][c] = 32'd5;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) b1[r][c] = 32'd4;
      repeat (3) @(negedge clk);
      rst0 = 1'b0;
      rst1 = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk_eq("idle0", all_out(0), 64'd0);
         chk_eq("idle1", all_out(1), 64'd0);
      end

      run_pass(0, -1, 0);
      run_pass(0, 2, 0);
      run_pass(0, 5, 5);
      run_pass(0, -1, 0);

      for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
         a0[r][c] = 32'hFFFF_FFFF;
         b0[r][c] = 32'hFFFF_FFFF;
      end
      run_pass(0, -1, 0);
      chk_eq("width_max", obs(0, SEL_PROD), 64'hFFFF_FFFE_0000_0001);

      repeat (3) begin
         for (int r = 0; r < 2; r++) for (int c = 0; c < 2; c++) begin
            a0[r][c] = $urandom;
            b0[r][c] = $urandom;
         end
         run_pass(0, $urandom_range(1, 8), 0);
      end

      run_pass(1, 10, 0);
      chk_eq("const_product", obs(1, SEL_PROD), 64'd20);
      for (int r = 0; r < 3; r++) for (int c = 0; c < 5; c++) a1[r][c] = $urandom;
      for (int r = 0; r < 5; r++) for (int c = 0; c < 5; c++) b1[r][c] = $urandom;
      run_pass(1, $urandom_range(1, 75), 0);
      run_pass(1, -1, 30);
      run_pass(1, -1, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
